softmax_row_ctrl: RTL and testbench

//  Sequences one I_SOFTMAX datapath over a row of N int32 scores held in a local SRAM.

---
 rtl/softmax_row_ctrl.sv | 127 ++++++++++++
 tb/tb_softmax_row_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_row_ctrl.sv
// Row sequencer for one softmax datapath: clears it, then runs MAX, ACC and OUT
// read passes over N SRAM scores with strobes aligned to the SRAM read latency.
module softmax_row_ctrl #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sm_rst_n,
  output logic              sm_en_max,
  output logic              sm_en_acc,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int C_W = ADDR_W + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAX,
    S_ACC,
    S_OUT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nxt_state;
  logic [C_W-1:0]    r_c;
  logic [C_W-1:0]    w_nxt_c;
  logic [C_W-1:0]    w_pass_len;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_in_base;
  logic [ADDR_W-1:0] r_out_base;
  logic [ADDR_W-1:0] w_k;
  logic              w_last;
  logic              w_in_pass;
  logic              w_rd;
  logic              w_stb;

  assign w_pass_len = {3'b000, r_len} + C_W'(RD_LAT);
  assign w_last     = (r_c == w_pass_len - C_W'(1));

  always_comb begin
    // NOTE: defaults first, so no path leaves a value unassigned and infers a latch.
    w_nxt_state = r_state;
    w_nxt_c     = r_c;
    case (r_state)
      S_IDLE: begin
        w_nxt_c = '0;
        if (start) w_nxt_state = (len == '0) ? S_DONE : S_CLR;
      end
      S_CLR: begin
        w_nxt_state = S_MAX;
        w_nxt_c     = '0;
      end
      S_MAX, S_ACC, S_OUT: begin
        if (w_last) begin
          w_nxt_c = '0;
          case (r_state)
            S_MAX:   w_nxt_state = S_ACC;
            S_ACC:   w_nxt_state = S_OUT;
            default: w_nxt_state = S_DONE;
          endcase
        end else begin
          w_nxt_c = r_c + C_W'(1);
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  // The strobe window c in [RD_LAT, N+RD_LAT) is exactly rd_en delayed by RD_LAT within a pass,
  // and it dies with the pass state, so a reset leaves no delayed strobe in flight.
  assign w_in_pass = (w_nxt_state == S_MAX) || (w_nxt_state == S_ACC) || (w_nxt_state == S_OUT);
  assign w_rd      = w_in_pass && (w_nxt_c < {3'b000, r_len});
  assign w_stb     = w_in_pass && (w_nxt_c >= C_W'(RD_LAT));
  assign w_k       = w_nxt_c[ADDR_W-1:0] - ADDR_W'(RD_LAT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_c        <= '0;
      r_len      <= '0;
      r_in_base  <= '0;
      r_out_base <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      sm_rst_n   <= 1'b0;
      sm_en_max  <= 1'b0;
      sm_en_acc  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      r_state <= w_nxt_state;
      r_c     <= w_nxt_c;
      if (r_state == S_IDLE && start) begin
        r_len      <= len;
        r_in_base  <= in_base;
        r_out_base <= out_base;
      end
      busy      <= w_in_pass || (w_nxt_state == S_CLR);
      done      <= (w_nxt_state == S_DONE);
      sm_rst_n  <= (w_nxt_state != S_CLR);
      rd_en     <= w_rd;
      rd_addr   <= w_rd ? (r_in_base + w_nxt_c[ADDR_W-1:0]) : '0;
      sm_en_max <= w_stb && (w_nxt_state == S_MAX);
      sm_en_acc <= w_stb && (w_nxt_state == S_ACC);
      wr_en     <= w_stb && (w_nxt_state == S_OUT);
      wr_addr   <= (w_stb && (w_nxt_state == S_OUT)) ? (r_out_base + w_k) : '0;
    end
  end

endmodule

// File: tb/tb_softmax_row_ctrl.sv
// Bench for softmax_row_ctrl: two instances (RD_LAT 1 and 3) on shared stimulus, checked per
// cycle against a timing model built from the row schedule, plus a stand-in softmax datapath.
module tb_softmax_row_ctrl;

  localparam int AW = 10;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          sm_rst_n;
    logic          sm_en_max;
    logic          sm_en_acc;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
  } out_t;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [AW-1:0] len;
  logic [AW-1:0] in_base;
  logic [AW-1:0] out_base;

  logic          a_busy, a_done, a_rd_en, a_sm_rst_n, a_en_max, a_en_acc, a_wr_en;
  logic [AW-1:0] a_rd_addr, a_wr_addr;
  logic          b_busy, b_done, b_rd_en, b_sm_rst_n, b_en_max, b_en_acc, b_wr_en;
  logic [AW-1:0] b_rd_addr, b_wr_addr;

  softmax_row_ctrl #(.ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .in_base(in_base), .out_base(out_base),
    .busy(a_busy), .done(a_done), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .sm_rst_n(a_sm_rst_n),
    .sm_en_max(a_en_max), .sm_en_acc(a_en_acc), .wr_en(a_wr_en), .wr_addr(a_wr_addr)
  );

  softmax_row_ctrl #(.ADDR_W(AW), .RD_LAT(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .in_base(in_base), .out_base(out_base),
    .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .sm_rst_n(b_sm_rst_n),
    .sm_en_max(b_en_max), .sm_en_acc(b_en_acc), .wr_en(b_wr_en), .wr_addr(b_wr_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Per-instance row model: accepted row and the edge number it was accepted on.
  int            lat [2] = '{1, 3};
  bit            act [2];
  int            acc_e [2];
  int            row_n [2];
  logic [AW-1:0] row_ib [2];
  logic [AW-1:0] row_ob [2];
  int            edge_no = 0;
  bit            rst_now;

  function automatic int done_cycle(input int n, input int l);
    return (n == 0) ? 1 : 2 + 3 * (n + l);
  endfunction

  // Expected outputs d cycles after the accepting edge, from the row schedule.
  function automatic out_t model(input bit rst_s, input bit active, input int d, input int n,
                                 input int l, input logic [AW-1:0] ib, input logic [AW-1:0] ob);
    out_t o;
    int   p_len, pass, c;
    o = '0;
    if (rst_s) return o;
    o.sm_rst_n = 1'b1;
    if (!active) return o;
    if (d == done_cycle(n, l)) begin
      o.done = 1'b1;
      return o;
    end
    if (n == 0 || d > done_cycle(n, l)) return o;
    o.busy = 1'b1;
    if (d == 1) begin
      o.sm_rst_n = 1'b0;
      return o;
    end
    p_len = n + l;
    pass  = (d - 2) / p_len;
    c     = (d - 2) % p_len;
    if (c < n) begin
      o.rd_en   = 1'b1;
      o.rd_addr = ib + AW'(c);
    end
    if (c >= l) begin
      case (pass)
        0: o.sm_en_max = 1'b1;
        1: o.sm_en_acc = 1'b1;
        default: begin
          o.wr_en   = 1'b1;
          o.wr_addr = ob + AW'(c - l);
        end
      endcase
    end
    return o;
  endfunction

  function automatic out_t pack(input logic bz, input logic dn, input logic re,
                                input logic [AW-1:0] ra, input logic srn, input logic em,
                                input logic ea, input logic we, input logic [AW-1:0] wa);
    out_t o;
    o.busy      = bz;
    o.done      = dn;
    o.rd_en     = re;
    o.rd_addr   = re ? ra : '0;
    o.sm_rst_n  = srn;
    o.sm_en_max = em;
    o.sm_en_acc = ea;
    o.wr_en     = we;
    o.wr_addr   = we ? wa : '0;
    return o;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, edge_no, obs, expv);
    end
  endtask

  // One clock: update the row model from the sampled inputs, then compare both instances.
  task automatic step();
    out_t ob_v, ex_v;
    @(posedge CLK);
    edge_no++;
    rst_now = RST;
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        act[i] = 1'b0;
      end else if (start && (!act[i] || (edge_no - acc_e[i]) > done_cycle(row_n[i], lat[i]))) begin
        act[i]    = 1'b1;
        acc_e[i]  = edge_no;
        row_n[i]  = int'(len);
        row_ib[i] = in_base;
        row_ob[i] = out_base;
      end
    end
    #1;
    ob_v = pack(a_busy, a_done, a_rd_en, a_rd_addr, a_sm_rst_n, a_en_max, a_en_acc, a_wr_en, a_wr_addr);
    ex_v = model(rst_now, act[0], edge_no - acc_e[0] + 1, row_n[0], lat[0], row_ib[0], row_ob[0]);
    check("outs_lat1", longint'(ob_v), longint'(ex_v));
    ob_v = pack(b_busy, b_done, b_rd_en, b_rd_addr, b_sm_rst_n, b_en_max, b_en_acc, b_wr_en, b_wr_addr);
    ex_v = model(rst_now, act[1], edge_no - acc_e[1] + 1, row_n[1], lat[1], row_ib[1], row_ob[1]);
    check("outs_lat3", longint'(ob_v), longint'(ex_v));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic go(input int n, input logic [AW-1:0] ib, input logic [AW-1:0] ob);
    len      = AW'(n);
    in_base  = ib;
    out_base = ob;
    pulse_start();
  endtask

  // Stand-in softmax datapath on the RD_LAT=1 instance; e(x) = 1024 >> (max - x).
  int     mem [1024];
  int     q_in;
  int     q_max;
  longint acc;
  int     wr_a_q [$];
  int     wr_d_q [$];

  function automatic int expv(input int dlt);
    if (dlt >= 0) return 1024;
    return (-dlt > 20) ? 0 : (1024 >> (-dlt));
  endfunction

  always @(posedge CLK) begin
    q_in <= a_rd_en ? mem[a_rd_addr] : 0;
    if (!a_sm_rst_n) begin
      q_max <= -2147483647;
      acc   <= 0;
    end else begin
      if (a_en_max && q_in > q_max) q_max <= q_in;
      if (a_en_acc) acc <= acc + longint'(expv(q_in - q_max));
    end
    if (a_wr_en) begin
      wr_a_q.push_back(int'(a_wr_addr));
      wr_d_q.push_back(expv(q_in - q_max));
    end
  end

  initial begin
    int scores [4];
    int ref_max;
    longint ref_acc;
    int rn;

    scores = '{3, 1, -2, 5};
    for (int i = 0; i < 1024; i++) mem[i] = int'($urandom_range(0, 20)) - 10;
    RST = 1'b1; start = 1'b0; len = '0; in_base = '0; out_base = '0;
    for (int i = 0; i < 2; i++) act[i] = 1'b0;

    run(2);
    RST = 1'b0;
    run(2);

    // Row of 4 from 0x10 to 0x20.
    go(4, 10'h010, 10'h020);
    run(30);

    // Empty row.
    go(0, 10'h055, 10'h066);
    run(4);

    // Read address wrap-around.
    go(4, 10'h3FE, 10'h030);
    run(30);

    // Starts during ACC and during the DONE cycle are ignored; the one after done is taken.
    go(4, 10'h010, 10'h020);
    run(8);
    pulse_start();
    run(7);
    pulse_start();
    pulse_start();
    run(45);

    // Reset during the second ACC strobe, then a clean row.
    go(4, 10'h010, 10'h020);
    run(8);
    RST = 1'b1;
    step();
    RST = 1'b0;
    run(20);
    go(4, 10'h010, 10'h020);
    run(30);

    // Random rows.
    for (int r = 0; r < 6; r++) begin
      rn = int'($urandom_range(0, 12));
      go(rn, AW'($urandom), AW'($urandom));
      run(2 + 3 * (rn + 3) + 2);
    end

    // Full-datapath row: scores [3,1,-2,5].
    for (int i = 0; i < 4; i++) mem[10'h040 + i] = scores[i];
    wr_a_q.delete();
    wr_d_q.delete();
    go(4, 10'h040, 10'h080);
    run(18);
    ref_max = scores[0];
    for (int i = 1; i < 4; i++) if (scores[i] > ref_max) ref_max = scores[i];
    ref_acc = 0;
    for (int i = 0; i < 4; i++) ref_acc += longint'(expv(scores[i] - ref_max));
    check("dp_q_max", longint'(q_max), longint'(ref_max));
    check("dp_acc", acc, ref_acc);
    check("dp_wr_count", longint'(wr_a_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_a_q.size(); i++) begin
      check("dp_wr_addr", longint'(wr_a_q[i]), longint'(10'h080 + i));
      check("dp_wr_data", longint'(wr_d_q[i]), longint'(expv(scores[i] - ref_max)));
    end
    run(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
